// File: rtl/spectrum_peak_hold_if.sv
// ============================================================================
//  Module      : spectrum_peak_hold_if
//  Description : Update, frame and readout signals of the peak-hold store.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spectrum_peak_hold_if #(
    parameter int N_BINS = 8,
    parameter int MAG_W  = 8
);
    localparam int BW = $clog2(N_BINS);

    logic             clear;
    logic             in_valid;
    logic [BW-1:0]    in_bin;
    logic [MAG_W-1:0] in_mag;
    logic             frame_end;
    logic             rd_start;
    logic             rd_ready;
    logic             rd_valid;
    logic [BW-1:0]    rd_bin;
    logic [MAG_W-1:0] rd_data;
    logic             rd_last;
    logic             busy;

    modport master (
        output clear, in_valid, in_bin, in_mag, frame_end, rd_start, rd_ready,
        input  rd_valid, rd_bin, rd_data, rd_last, busy
    );

    modport slave (
        input  clear, in_valid, in_bin, in_mag, frame_end, rd_start, rd_ready,
        output rd_valid, rd_bin, rd_data, rd_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/spectrum_peak_hold.sv
// ============================================================================
//  Module      : spectrum_peak_hold
//  Description : Per-bin running-maximum store with valid/ready serial readout.
//                Optional periodic decay enabled by SPECTRUM_PEAK_DECAY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_peak_hold #(
    parameter int N_BINS      = 8,
    parameter int MAG_W       = 8,
    parameter int DECAY_DIV   = 4,
    parameter int DECAY_SHIFT = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    spectrum_peak_hold_if.slave bus
);
    localparam int BW = $clog2(N_BINS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MAG_W-1:0] peak_q [N_BINS];
    logic [MAG_W-1:0] peak_d [N_BINS];
    logic             rd_valid_q, rd_valid_d;
    logic [BW-1:0]    rd_bin_q, rd_bin_d;
    logic [MAG_W-1:0] rd_data_q, rd_data_d;
    logic             rd_last_q, rd_last_d;
    logic             busy_q, busy_d;
    logic [BW-1:0]    rd_bin_nxt;

`ifdef SPECTRUM_PEAK_DECAY_EN
    localparam int CW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          decay_fire;

    function automatic logic [MAG_W-1:0] decay_step(input logic [MAG_W-1:0] p);
        logic [MAG_W-1:0] d;
        d = p >> DECAY_SHIFT;
        if (d == '0 && p != '0) begin
            d = MAG_W'(1);
        end
        return p - d;
    endfunction

    always_comb begin
        decay_fire  = bus.frame_end && (frame_cnt_q == CW'(DECAY_DIV - 1));
        frame_cnt_d = frame_cnt_q;
        if (bus.clear) begin
            frame_cnt_d = '0;
        end else if (bus.frame_end) begin
            frame_cnt_d = decay_fire ? '0 : frame_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    logic unused_decay_cfg;
    assign unused_decay_cfg = bus.frame_end ^ (DECAY_DIV > 0) ^ (DECAY_SHIFT > 0);
`endif

    // Decay is applied first so a same-cycle update competes against the decayed value.
    always_comb begin
        for (int i = 0; i < N_BINS; i++) begin
`ifdef SPECTRUM_PEAK_DECAY_EN
            peak_d[i] = decay_fire ? decay_step(peak_q[i]) : peak_q[i];
`else
            peak_d[i] = peak_q[i];
`endif
            if (bus.in_valid && bus.in_bin == BW'(i) && bus.in_mag > peak_d[i]) begin
                peak_d[i] = bus.in_mag;
            end
            if (bus.clear) begin
                peak_d[i] = '0;
            end
        end
    end

    // Beats are loaded from peak_d so a beat sees same-cycle updates, decay or clear.
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_bin_d   = rd_bin_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        busy_d     = busy_q;
        rd_bin_nxt = rd_bin_q + BW'(1);
        case (state_q)
            IDLE: begin
                if (bus.rd_start) begin
                    state_d    = READ;
                    rd_valid_d = 1'b1;
                    rd_bin_d   = '0;
                    rd_data_d  = peak_d[0];
                    rd_last_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            READ: begin
                if (bus.rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                        rd_bin_d   = '0;
                        rd_data_d  = '0;
                        rd_last_d  = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        rd_bin_d  = rd_bin_nxt;
                        rd_data_d = peak_d[rd_bin_nxt];
                        rd_last_d = (rd_bin_nxt == BW'(N_BINS - 1));
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_bin_q   <= '0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                peak_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_bin_q   <= rd_bin_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            for (int i = 0; i < N_BINS; i++) begin
                peak_q[i] <= peak_d[i];
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_bin   = rd_bin_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_peak_hold.sv
// ============================================================================
//  Module      : tb_spectrum_peak_hold
//  Description : Randomised and directed scoreboard bench for spectrum_peak_hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spectrum_peak_hold;
    localparam int N_BINS      = 8;
    localparam int MAG_W       = 8;
    localparam int DECAY_DIV   = 4;
    localparam int DECAY_SHIFT = 3;
    localparam int BW          = $clog2(N_BINS);
`ifdef SPECTRUM_PEAK_DECAY_EN
    localparam bit DECAY_ON = 1'b1;
`else
    localparam bit DECAY_ON = 1'b0;
`endif

    typedef struct {
        int bin;
        int data;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spectrum_peak_hold_if #(.N_BINS(N_BINS), .MAG_W(MAG_W)) ifc ();

    spectrum_peak_hold #(
        .N_BINS(N_BINS), .MAG_W(MAG_W), .DECAY_DIV(DECAY_DIV), .DECAY_SHIFT(DECAY_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    int    checks   = 0;
    int    failures = 0;
    int    model [N_BINS];
    int    frames   = 0;
    bit    reading  = 1'b0;
    int    cur      = 0;
    bit    exp_busy = 1'b0;
    beat_t sb [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decayed(input int p);
        int d;
        d = p >> DECAY_SHIFT;
        if (d == 0 && p > 0) d = 1;
        return p - d;
    endfunction

    task automatic idle_in();
        ifc.clear     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_bin    = '0;
        ifc.in_mag    = '0;
        ifc.frame_end = 1'b0;
        ifc.rd_start  = 1'b0;
        ifc.rd_ready  = 1'b1;
    endtask

    // Predicts the effect of the inputs currently driven, then advances one clock.
    task automatic step();
        int  nxt [N_BINS];
        bit  fire;
        beat_t b;
        fire = 1'b0;
        for (int i = 0; i < N_BINS; i++) nxt[i] = model[i];
        if (ifc.clear) begin
            for (int i = 0; i < N_BINS; i++) nxt[i] = 0;
            frames = 0;
        end else begin
            if (DECAY_ON && ifc.frame_end) begin
                frames = (frames + 1) % DECAY_DIV;
                fire   = (frames == 0);
            end
            if (fire) for (int i = 0; i < N_BINS; i++) nxt[i] = decayed(model[i]);
            if (ifc.in_valid && int'(ifc.in_bin) < N_BINS && int'(ifc.in_mag) > nxt[int'(ifc.in_bin)])
                nxt[int'(ifc.in_bin)] = int'(ifc.in_mag);
        end
        if (!reading) begin
            if (ifc.rd_start) begin
                reading = 1'b1;
                cur     = 0;
                b.bin = 0; b.data = nxt[0]; b.last = 1'b0;
                sb.push_back(b);
            end
        end else if (ifc.rd_ready) begin
            if (cur == N_BINS - 1) begin
                reading = 1'b0;
            end else begin
                cur++;
                b.bin = cur; b.data = nxt[cur]; b.last = (cur == N_BINS - 1);
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < N_BINS; i++) model[i] = nxt[i];
        exp_busy = reading;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", int'(ifc.rd_valid), 0);
        chk("rst_bin",   int'(ifc.rd_bin),   0);
        chk("rst_data",  int'(ifc.rd_data),  0);
        chk("rst_last",  int'(ifc.rd_last),  0);
        chk("rst_busy",  int'(ifc.busy),     0);
        for (int i = 0; i < N_BINS; i++) model[i] = 0;
        frames   = 0;
        reading  = 1'b0;
        exp_busy = 1'b0;
        sb.delete();
        idle_in();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic upd(input int b, input int m);
        ifc.in_valid = 1'b1;
        ifc.in_bin   = BW'(b);
        ifc.in_mag   = MAG_W'(m);
        step();
        ifc.in_valid = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            ifc.frame_end = 1'b1;
            step();
            ifc.frame_end = 1'b0;
            step();
        end
    endtask

    // mode 0: always ready, 1: alternating, 2: random
    task automatic read_all(input int mode);
        int n;
        ifc.rd_start = 1'b1;
        step();
        ifc.rd_start = 1'b0;
        n = 0;
        while (reading && n < 300) begin
            ifc.rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(1));
            step();
            n++;
        end
        ifc.rd_ready = 1'b1;
        step();
    endtask

    // Checks every beat at the moment it transfers.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("busy", int'(ifc.busy), int'(exp_busy));
                if (ifc.rd_valid && ifc.rd_ready) begin
                    if (sb.size() == 0) begin
                        chk("beat_unexpected", int'(ifc.rd_bin), -1);
                    end else begin
                        b = sb.pop_front();
                        chk("beat_bin",  int'(ifc.rd_bin),  b.bin);
                        chk("beat_data", int'(ifc.rd_data), b.data);
                        chk("beat_last", int'(ifc.rd_last), int'(b.last));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle_in();
        @(posedge clk);
        #2;
        do_reset();

        // T1: reset in the middle of a readout
        upd(5, 200);
        ifc.rd_start = 1'b1;
        ifc.rd_ready = 1'b0;
        step();
        ifc.rd_start = 1'b0;
        step();
        do_reset();
        read_all(0);

        // T2: max-hold
        upd(3, 40);
        upd(3, 25);
        upd(3, 90);
        read_all(0);

        // T3: decay cadence
        do_reset();
        upd(0, 80);
        upd(1, 5);
        pulse(3);
        read_all(0);
        pulse(1);
        read_all(1);

        // T4: decay/update collision
        for (int m = 0; m < 2; m++) begin
            do_reset();
            upd(0, 80);
            pulse(3);
            ifc.frame_end = 1'b1;
            upd(0, (m == 0) ? 75 : 60);
            ifc.frame_end = 1'b0;
            read_all(0);
        end

        // T5: backpressure, restart attempt ignored
        do_reset();
        for (int i = 0; i < N_BINS; i++) upd(i, 10 * i + 7);
        ifc.rd_start = 1'b1;
        ifc.rd_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_bin",  int'(ifc.rd_bin),  0);
            chk("bp_data", int'(ifc.rd_data), model[0]);
        end
        n = 0;
        while (reading && n < 100) begin
            ifc.rd_ready = ((n % 2) == 0);
            step();
            n++;
        end
        ifc.rd_start = 1'b0;
        ifc.rd_ready = 1'b1;
        step();
        chk("bp_idle_valid", int'(ifc.rd_valid), 0);

        // T6: clear collisions
        upd(2, 50);
        ifc.clear = 1'b1;
        upd(2, 50);
        ifc.clear = 1'b0;
        read_all(0);
        for (int i = 0; i < N_BINS; i++) upd(i, 100 + i);
        ifc.rd_start = 1'b1;
        step();
        ifc.rd_start = 1'b0;
        n = 0;
        while (reading && n < 100) begin
            ifc.rd_ready = 1'b1;
            ifc.clear    = (cur == 3);
            step();
            ifc.clear = 1'b0;
            n++;
        end
        step();
        chk("clr_idle_busy", int'(ifc.busy), 0);

        // Randomised traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            ifc.in_valid  = 1'($urandom_range(1));
            ifc.in_bin    = BW'($urandom);
            ifc.in_mag    = MAG_W'($urandom);
            ifc.frame_end = ($urandom_range(3) == 0);
            ifc.clear     = ($urandom_range(60) == 0);
            ifc.rd_start  = ($urandom_range(7) == 0);
            ifc.rd_ready  = ($urandom_range(2) != 0);
            step();
        end
        idle_in();
        n = 0;
        while (reading && n < 100) begin
            step();
            n++;
        end
        step();
        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
